// File: rtl/microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// microwave_timer_ctrl
//
// Control FSM for the microwave's MM:SS countdown chain, which is built from
// cascaded BCD down-counters. Keypad digits are collected into a 4-digit BCD
// entry buffer, and that buffer is loaded into the chain. While cooking, the
// 1 Hz tick is gated into the chain's count enable and the magnetron is
// driven. The FSM also handles the door interlock, pause/resume, cancel and
// the end-of-cook beep.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_i           asynchronous, active-high reset
//   tick_1hz_i      one-cycle pulse per second
//   start_i         start/resume key pulse
//   stop_i          stop/cancel key pulse
//   digit_valid_i   keypad digit strobe
//   digit_i         keypad digit value (valid with digit_valid_i)
//   door_closed_i   1 = door shut (level)
//   timer_zero_i    1 = chain reads 00:00 (combinational from the chain)
//   timer_data_o    entry buffer {min_tens, min_ones, sec_tens, sec_ones}, BCD
//   timer_loadn_o   active-low load strobe to the chain (registered)
//   timer_clrn_o    active-low clear strobe to the chain (registered)
//   timer_enable_o  chain count enable (combinational)
//   magnetron_on_o  magnetron enable (registered)
//   beep_o          end-of-cook beeper (registered)
//   state_o         current state encoding, for debug/display
// -----------------------------------------------------------------------------
module microwave_timer_ctrl #(
  parameter int BEEP_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_1hz_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        digit_valid_i,
  input  logic [3:0]  digit_i,
  input  logic        door_closed_i,
  input  logic        timer_zero_i,
  output logic [15:0] timer_data_o,
  output logic        timer_loadn_o,
  output logic        timer_clrn_o,
  output logic        timer_enable_o,
  output logic        magnetron_on_o,
  output logic        beep_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    LOAD    = 3'd2,
    COOKING = 3'd3,
    PAUSED  = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int CNT_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);

  state_e           state_q,    state_d;
  logic [15:0]      buffer_q,   buffer_d;
  logic [CNT_W-1:0] beep_cnt_q, beep_cnt_d;
  logic             loadn_q,    loadn_d;
  logic             clrn_q,     clrn_d;
  logic             mag_q,      mag_d;
  logic             beep_q,     beep_d;

  logic digit_ok;

  // A digit whose predecessor in sec_ones is above 5 would shift an invalid
  // seconds-tens value into the buffer, so it is refused.
  assign digit_ok = digit_valid_i && (digit_i <= 4'd9) && (buffer_q[3:0] <= 4'd5);

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    buffer_d   = buffer_q;
    beep_cnt_d = '0;
    clrn_d     = 1'b1;

    unique case (state_q)
      IDLE, ENTRY: begin
        // Stop outranks start, and start outranks digit entry. A start that
        // cannot be honoured still consumes the cycle's digit.
        if (stop_i) begin
          state_d  = IDLE;
          buffer_d = '0;
        end else if (start_i) begin
          if (state_q == ENTRY && door_closed_i && buffer_q != 16'h0000)
            state_d = LOAD;
        end else if (digit_ok) begin
          buffer_d = {buffer_q[11:0], digit_i};
          state_d  = ENTRY;
        end
      end

      LOAD: begin
        state_d  = COOKING;
        buffer_d = '0;
      end

      COOKING: begin
        // Door-open outranks both stop and the end of the count.
        if (!door_closed_i || stop_i) state_d = PAUSED;
        else if (timer_zero_i)        state_d = DONE;
      end

      PAUSED: begin
        if (stop_i) begin
          state_d = IDLE;
          clrn_d  = 1'b0;
        end else if (start_i && door_closed_i) begin
          state_d = COOKING;
        end
      end

      DONE: begin
        if (stop_i || beep_cnt_q == BEEP_LAST) state_d = IDLE;
        else                                   beep_cnt_d = beep_cnt_q + 1'b1;
      end

      default: state_d = IDLE;
    endcase

    // Registered strobes follow the state they belong to, so they switch on
    // the same edge as the state itself.
    loadn_d = (state_d != LOAD);
    mag_d   = (state_d == COOKING);
    beep_d  = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      buffer_q   <= '0;
      beep_cnt_q <= '0;
      loadn_q    <= 1'b1;
      clrn_q     <= 1'b0;
      mag_q      <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buffer_q   <= buffer_d;
      beep_cnt_q <= beep_cnt_d;
      loadn_q    <= loadn_d;
      clrn_q     <= clrn_d;
      mag_q      <= mag_d;
      beep_q     <= beep_d;
    end
  end

  // Blocking the tick once the chain reads zero keeps it from wrapping.
  assign timer_enable_o = (state_q == COOKING) && tick_1hz_i && !timer_zero_i;

  assign timer_data_o   = buffer_q;
  assign timer_loadn_o  = loadn_q;
  assign timer_clrn_o   = clrn_q;
  assign magnetron_on_o = mag_q;
  assign beep_o         = beep_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
module tb_microwave_timer_ctrl;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_COOKING = 3'd3;
  localparam logic [2:0] S_PAUSED  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1hz, start, stop, digit_valid, door_closed, timer_zero;
  logic [3:0]  digit;
  logic [15:0] timer_data;
  logic        timer_loadn, timer_clrn, timer_enable, magnetron_on, beep;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  microwave_timer_ctrl #(.BEEP_CYCLES(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tick_1hz_i     (tick_1hz),
    .start_i        (start),
    .stop_i         (stop),
    .digit_valid_i  (digit_valid),
    .digit_i        (digit),
    .door_closed_i  (door_closed),
    .timer_zero_i   (timer_zero),
    .timer_data_o   (timer_data),
    .timer_loadn_o  (timer_loadn),
    .timer_clrn_o   (timer_clrn),
    .timer_enable_o (timer_enable),
    .magnetron_on_o (magnetron_on),
    .beep_o         (beep),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key_digit(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    step();
    digit_valid = 1'b0;
    digit       = 4'd0;
  endtask

  task automatic key_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic key_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; start = 1'b0; stop = 1'b0;
    digit_valid = 1'b0; digit = 4'd0; door_closed = 1'b1; timer_zero = 1'b0;

    // ---------------- reset state ----------------
    step();
    tick_1hz = 1'b1; #1;
    check("rst_state",  16'(state), 16'(S_IDLE));
    check("rst_loadn",  16'(timer_loadn), 16'd1);
    check("rst_clrn",   16'(timer_clrn), 16'd0);
    check("rst_mag",    16'(magnetron_on), 16'd0);
    check("rst_beep",   16'(beep), 16'd0);
    check("rst_data",   timer_data, 16'h0000);
    check("rst_enable", 16'(timer_enable), 16'd0);
    tick_1hz = 1'b0;
    step();
    rst = 1'b0;
    check("clrn_held_until_edge", 16'(timer_clrn), 16'd0);
    step();
    check("clrn_after_release", 16'(timer_clrn), 16'd1);

    // ---------------- entry 1,3,0 then start ----------------
    key_digit(4'd1);
    check("entry_state", 16'(state), 16'(S_ENTRY));
    check("entry_d1", timer_data, 16'h0001);
    key_digit(4'd3);
    check("entry_d13", timer_data, 16'h0013);
    key_digit(4'd0);
    check("entry_d130", timer_data, 16'h0130);
    key_start();
    check("load_state", 16'(state), 16'(S_LOAD));
    check("load_loadn", 16'(timer_loadn), 16'd0);
    check("load_data", timer_data, 16'h0130);
    check("load_mag", 16'(magnetron_on), 16'd0);
    step();
    check("cook_state", 16'(state), 16'(S_COOKING));
    check("cook_loadn", 16'(timer_loadn), 16'd1);
    check("cook_mag", 16'(magnetron_on), 16'd1);
    check("cook_buf_cleared", timer_data, 16'h0000);
    tick_1hz = 1'b1; #1;
    check("cook_tick_fwd", 16'(timer_enable), 16'd1);
    step();
    tick_1hz = 1'b0; #1;
    check("cook_no_tick", 16'(timer_enable), 16'd0);

    // ---------------- door open pause / resume ----------------
    door_closed = 1'b0;
    step();
    check("door_pause_state", 16'(state), 16'(S_PAUSED));
    check("door_pause_mag", 16'(magnetron_on), 16'd0);
    tick_1hz = 1'b1; #1;
    check("paused_tick_drop", 16'(timer_enable), 16'd0);
    step();
    tick_1hz = 1'b0;
    key_start();
    check("resume_door_open_blocked", 16'(state), 16'(S_PAUSED));
    door_closed = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("resume_state", 16'(state), 16'(S_COOKING));
    check("resume_mag", 16'(magnetron_on), 16'd1);
    check("resume_no_load", 16'(timer_loadn), 16'd1);

    // stop and start together while cooking -> stop wins
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    check("stop_start_pause", 16'(state), 16'(S_PAUSED));
    check("stop_start_mag", 16'(magnetron_on), 16'd0);

    // stop in PAUSED -> IDLE with a one-cycle clear strobe
    key_stop();
    check("cancel_state", 16'(state), 16'(S_IDLE));
    check("cancel_clrn", 16'(timer_clrn), 16'd0);
    step();
    check("cancel_clrn_release", 16'(timer_clrn), 16'd1);

    // ---------------- entry rejects ----------------
    key_start();
    check("idle_start_ignored", 16'(state), 16'(S_IDLE));
    key_digit(4'hA);
    check("reject_A_state", 16'(state), 16'(S_IDLE));
    check("reject_A_data", timer_data, 16'h0000);
    key_digit(4'd7);
    check("entry_d7", timer_data, 16'h0007);
    key_digit(4'd2);
    check("reject_after_7", timer_data, 16'h0007);
    door_closed = 1'b0;
    key_start();
    check("start_door_open", 16'(state), 16'(S_ENTRY));
    door_closed = 1'b1;
    key_stop();
    check("entry_stop_state", 16'(state), 16'(S_IDLE));
    check("entry_stop_clear", timer_data, 16'h0000);
    key_digit(4'd0);
    check("zero_digit_entry", 16'(state), 16'(S_ENTRY));
    key_start();
    check("start_zero_buffer", 16'(state), 16'(S_ENTRY));

    // ---------------- cook 00:02 to completion ----------------
    key_digit(4'd2);
    check("entry_0002", timer_data, 16'h0002);
    key_start();
    step();
    check("cook2_state", 16'(state), 16'(S_COOKING));
    tick_1hz = 1'b1; #1;
    check("cook2_tick1", 16'(timer_enable), 16'd1);
    step();
    tick_1hz = 1'b0;
    step();
    tick_1hz = 1'b1; #1;
    check("cook2_tick2", 16'(timer_enable), 16'd1);
    step();
    // the chain has reached 00:00
    timer_zero = 1'b1; #1;
    check("cook2_still_cooking", 16'(state), 16'(S_COOKING));
    check("cook2_no_wrap", 16'(timer_enable), 16'd0);
    step();
    tick_1hz = 1'b0;
    check("done_state", 16'(state), 16'(S_DONE));
    check("done_mag", 16'(magnetron_on), 16'd0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("done_beep_%0d", i), 16'(beep), 16'd1);
      step();
    end
    check("done_to_idle", 16'(state), 16'(S_IDLE));
    check("done_beep_off", 16'(beep), 16'd0);

    // ---------------- stop during DONE ----------------
    timer_zero = 1'b0;
    key_digit(4'd1);
    key_start();
    step();
    timer_zero = 1'b1;
    step();
    check("done2_state", 16'(state), 16'(S_DONE));
    key_stop();
    check("done_stop_state", 16'(state), 16'(S_IDLE));
    check("done_stop_beep", 16'(beep), 16'd0);

    // ---------------- async reset while cooking ----------------
    timer_zero = 1'b0;
    key_digit(4'd5);
    key_start();
    step();
    check("pre_rst_cook", 16'(state), 16'(S_COOKING));
    #2;
    rst = 1'b1;
    tick_1hz = 1'b1;
    #1;
    check("arst_state", 16'(state), 16'(S_IDLE));
    check("arst_mag", 16'(magnetron_on), 16'd0);
    check("arst_clrn", 16'(timer_clrn), 16'd0);
    check("arst_loadn", 16'(timer_loadn), 16'd1);
    check("arst_enable", 16'(timer_enable), 16'd0);
    tick_1hz = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("arst_clrn_release", 16'(timer_clrn), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/microwave_timer_ctrl.md
# microwave_timer_ctrl

Control FSM for the microwave's MM:SS countdown chain of cascaded BCD down-counters. It collects keypad digits into a 4-digit BCD entry buffer and loads the buffer into the timer. It gates the 1 Hz tick into the timer's count enable while cooking, and drives the magnetron enable. It also handles the door interlock, pause/resume, cancel, and the end-of-cook beep.

## Interface
- BEEP_CYCLES, 4: number of clock cycles `beep` stays high in DONE.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to their reset values.
- tick_1hz  in  1  one-cycle pulse, once per second.
- start  in  1  one-cycle pulse, start/resume key.
- stop  in  1  one-cycle pulse, stop/cancel key.
- digit_valid  in  1  one-cycle pulse, keypad digit present.
- digit  in  4  keypad digit value; valid when digit_valid=1.
- door_closed  in  1  1 = door shut (level).
- timer_zero  in  1  1 = counter chain reads 00:00 (combinational from the chain).
- timer_data  out  16  entry buffer {min_tens, min_ones, sec_tens, sec_ones} in BCD; reset 0.
- timer_loadn  out  1  active-low load strobe to the chain, registered; reset 1.
- timer_clrn  out  1  active-low clear strobe to the chain, registered; reset 0 while reset is high, then 1.
- timer_enable  out  1  count enable to the chain, combinational; 0 in reset.
- magnetron_on  out  1  registered; reset 0.
- beep  out  1  registered; reset 0.
- state  out  3  current state encoding, for debug/display; reset IDLE.

## Operation
- States and encodings: IDLE=0, ENTRY=1, LOAD=2, COOKING=3, PAUSED=4, DONE=5.
- Event priority within one cycle: stop, then start, then digit_valid. Lower-priority events in the same cycle are dropped.
- Digit entry is accepted only in IDLE and ENTRY.
  - A digit is rejected if digit > 9.
  - A digit is also rejected if the current sec_ones > 5, because that value would shift into sec_tens.
  - On accept, the buffer shifts left one digit, digit enters sec_ones, and min_tens is discarded. Example: 0000 → 1 → 0001 → 3 → 0013.
  - Any accepted digit takes IDLE → ENTRY.
- ENTRY + start + door_closed + buffer≠0 → LOAD. A start that fails any condition is ignored.
- ENTRY + stop → IDLE, buffer cleared to 0.
- LOAD lasts exactly one cycle with timer_loadn=0, then goes to COOKING. The buffer is cleared to 0 on exit from LOAD.
- COOKING:
  - magnetron_on=1.
  - timer_enable = tick_1hz & ~timer_zero, evaluated combinationally in COOKING only.
  - timer_zero=1 → DONE.
  - door_closed=0 → PAUSED. Door-open is checked before stop and zero.
  - stop → PAUSED.
- PAUSED:
  - magnetron_on=0, timer_enable=0; the chain holds its value.
  - start + door_closed → COOKING, with no reload.
  - stop → IDLE, with timer_clrn=0 for one cycle.
- DONE:
  - magnetron_on=0, beep=1 for BEEP_CYCLES cycles, then → IDLE.
  - stop in DONE → IDLE immediately, beep=0.
- IDLE: all strobes inactive. start is ignored.
- Door open in IDLE or ENTRY does not affect entry. It only blocks start.

## Timing
- Registered outputs (magnetron_on, beep, timer_loadn, timer_clrn) change on the same edge as the state change they belong to.
- start → timer_loadn low: 1 cycle. start → magnetron_on high: 2 cycles (LOAD then COOKING).
- Pause/resume latency: one edge from the door or key event to magnetron_on changing.
- Final tick: the tick taking the chain 00:01 → 00:00 is forwarded. On the next cycle timer_zero=1 and the FSM enters DONE on that edge. No tick is forwarded while timer_zero=1, so the chain never wraps.
- reset asserted mid-operation:
  - Immediately: magnetron_on=0, beep=0, buffer=0, timer_clrn=0, state=IDLE.
  - On the first edge after reset releases, timer_clrn returns to 1.
- tick_1hz arriving in LOAD or PAUSED is dropped.

## Test plan
- Digits 1,3,0 then start (door closed) → buffer 0130; timer_loadn low for exactly 1 cycle with timer_data=0130; magnetron_on=1 two cycles after start.
- Entry with digit 7 (buffer 0007) then digit 2 → rejected, buffer stays 0007. Digit 0xA → rejected.
- Cook 00:02 with ticks → timer_enable pulses twice. After 00:00, state=DONE, beep high for 4 cycles, then IDLE, magnetron_on=0.
- Door opened during COOKING → PAUSED next edge, magnetron_on=0, ticks not forwarded. Door closed plus start → COOKING with no load strobe.
- stop in PAUSED → timer_clrn low for 1 cycle, state IDLE. Start with door open or buffer 0000 → ignored, state unchanged.
- Stop and start in the same cycle during COOKING → PAUSED. Reset asserted in COOKING → all outputs at reset values asynchronously.
